alu_serial_ctrl: RTL

Bit-serial sequencer for the single-bit ALU slice (AND / OR / sum with B-invert and carry chain). It accepts a WIDTH-bit operation, presents operand bits LSB-first to one external slice over WIDTH cycles, and recirculates the slice carry through a register. It assembles the result and reports carry, signed overflow and zero. It sits between the instruction/control logic and one Alu1bit instance, which is instantiated beside it and wired through the alu_* ports.

---
 rtl/alu_serial_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial sequencer driving one external single-bit ALU slice
// Operands go out LSB-first over WIDTH cycles; the slice carry recirculates through carry_r.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_invertb,
  output logic [1:0]       alu_select,
  input  logic             alu_out,
  input  logic             alu_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry_r;

  logic [WIDTH-1:0] res_next;
  logic             last_bit;
  logic             logic_op;
  logic             running;

  assign running  = (state == S_RUN);
  assign res_next = {alu_out, res_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign logic_op = ~op_r[1];

  assign busy        = running;
  assign done        = (state == S_DONE);
  assign alu_a       = running & a_sh[0];
  assign alu_b       = running & b_sh[0];
  assign alu_cin     = running & carry_r;
  assign alu_select  = op_r;
  assign alu_invertb = (op_r == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_r      <= 2'b00;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry_r   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            op_r    <= op;
            a_sh    <= a_in;
            b_sh    <= b_in;
            res_sh  <= '0;
            cnt     <= '0;
            carry_r <= (op == 2'b11);
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          carry_r <= alu_cout;
          cnt     <= cnt + 1'b1;
          // carry_r still holds the carry into the MSB here; alu_cout is the carry out of it
          if (last_bit) begin
            state     <= S_DONE;
            result    <= res_next;
            carry_out <= alu_cout & ~logic_op;
            overflow  <= (carry_r ^ alu_cout) & ~logic_op;
            zero      <= (res_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
